ppu_byte_tx: RTL and testbench

Byte-stream transmitter that drives the PPU input port using the stb/ack four-phase handshake.
- Upstream logic (pattern generator, tile fetcher) pushes bytes into a small internal FIFO.
- The block serializes them one at a time onto data_o/stb_o, tracks the position within a PPU line, and realigns to line start on sync.

---
 rtl/ppu_pkg.sv | 22 ++
 rtl/ppu_tx_fifo.sv | 75 +++++++
 rtl/ppu_byte_tx.sv | 158 +++++++++++++++
 tb/tb_ppu_byte_tx.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU definitions: byte width, line geometry, transmit FSM and handshake phases.
package ppu_pkg;

  localparam int unsigned ByteW     = 8;
  localparam int unsigned LineBytes = 32;
  localparam int unsigned LineAw    = $clog2(LineBytes);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StStrobe  = 2'd1,
    StRelease = 2'd2
  } tx_state_e;

  // Four-phase handshake phases, encoded as {stb, ack}
  typedef enum logic [1:0] {
    PhIdle    = 2'b00,
    PhStrobe  = 2'b10,
    PhAck     = 2'b11,
    PhRelease = 2'b01
  } hs_phase_e;

endpackage

// File: rtl/ppu_tx_fifo.sv
// Transmit byte FIFO: registered pointers and occupancy, sticky overflow on write-while-full.
module ppu_tx_fifo
  import ppu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FIFO_AW    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en_i,
  input  logic [ByteW-1:0]   wr_data_i,
  input  logic               pop_i,
  input  logic               clr_overflow_i,
  output logic [ByteW-1:0]   head_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [FIFO_AW:0]   level_o,
  output logic               overflow_o
);

  logic [ByteW-1:0] mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               push;

  // full is taken from the pre-edge count, so a concurrent pop never frees a slot
  assign full_o     = (count_q == (FIFO_AW + 1)'(FIFO_DEPTH));
  assign empty_o    = (count_q == '0);
  assign level_o    = count_q;
  assign overflow_o = overflow_q;
  assign head_o     = mem_q[rd_ptr_q];
  assign push       = wr_en_i && !full_o;

  // Next-state for pointers, occupancy and overflow flag
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (clr_overflow_i) begin
      overflow_d = 1'b0;
    end else if (wr_en_i && full_o) begin
      overflow_d = 1'b1;
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/ppu_byte_tx.sv
// PPU byte transmitter: FIFO-fed stb/ack four-phase serializer with line position tracking.
// Optional ack timeout in STROBE is enabled by defining PPU_TX_TIMEOUT_EN.
module ppu_byte_tx
  import ppu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned FIFO_AW        = 3,
  parameter int unsigned LINE_BYTES     = LineBytes,
  parameter int unsigned LINE_AW        = LineAw
`ifdef PPU_TX_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sync,
  input  logic [ByteW-1:0]   wr_data,
  input  logic               wr_en,
  output logic               full,
  output logic               empty,
  output logic [FIFO_AW:0]   level,
  output logic               overflow,
  output logic [ByteW-1:0]   data_o,
  output logic               stb_o,
  input  logic               ack_o,
  output logic [LINE_AW-1:0] byte_idx,
  output logic               line_done,
  output logic               timeout
);

  tx_state_e          state_q, state_d;
  logic [ByteW-1:0]   data_q, data_d;
  logic               stb_q, stb_d;
  logic [LINE_AW-1:0] idx_q, idx_d;
  logic               line_done_q, line_done_d;
  logic [ByteW-1:0]   head;
  logic               pop;
  logic               acked;

`ifdef PPU_TX_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
  logic [ToW-1:0] cnt_q, cnt_d;
  logic           timeout_q, timeout_d;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  ppu_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .FIFO_AW    (FIFO_AW)
  ) u_fifo (
    .clk            (clk),
    .rst            (rst),
    .wr_en_i        (wr_en),
    .wr_data_i      (wr_data),
    .pop_i          (pop),
    .clr_overflow_i (sync),
    .head_o         (head),
    .full_o         (full),
    .empty_o        (empty),
    .level_o        (level),
    .overflow_o     (overflow)
  );

  assign data_o    = data_q;
  assign stb_o     = stb_q;
  assign byte_idx  = idx_q;
  assign line_done = line_done_q;

  // Handshake FSM next-state, line counter and sync realignment
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    stb_d       = stb_q;
    idx_d       = idx_q;
    line_done_d = 1'b0;
    pop         = 1'b0;
    acked       = 1'b0;
`ifdef PPU_TX_TIMEOUT_EN
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
`endif
    unique case (state_q)
      StIdle: begin
        // A still-high ack belongs to the previous byte; do not start until it drops
        if (!empty && !ack_o) begin
          data_d  = head;
          stb_d   = 1'b1;
          pop     = 1'b1;
          state_d = StStrobe;
`ifdef PPU_TX_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      StStrobe: begin
        if (ack_o) begin
          stb_d   = 1'b0;
          acked   = 1'b1;
          state_d = StRelease;
`ifdef PPU_TX_TIMEOUT_EN
        end else if (cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
          // Give up on this byte without advancing the line position
          stb_d     = 1'b0;
          timeout_d = 1'b1;
          state_d   = StRelease;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      StRelease: begin
        if (!ack_o) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (acked) begin
      idx_d       = idx_q + 1'b1;
      line_done_d = (idx_q == LINE_AW'(LINE_BYTES - 1));
    end
    // sync overrides a coincident ack: realign and suppress the line pulse
    if (sync) begin
      idx_d       = '0;
      line_done_d = 1'b0;
`ifdef PPU_TX_TIMEOUT_EN
      timeout_d   = 1'b0;
`endif
    end
  end

  // FSM and output registers; async reset drops stb_o immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      data_q      <= '0;
      stb_q       <= 1'b0;
      idx_q       <= '0;
      line_done_q <= 1'b0;
`ifdef PPU_TX_TIMEOUT_EN
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      stb_q       <= stb_d;
      idx_q       <= idx_d;
      line_done_q <= line_done_d;
`ifdef PPU_TX_TIMEOUT_EN
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_ppu_byte_tx.sv
// Scoreboard bench for ppu_byte_tx: queue-based FIFO/line model, random data and responder.
module tb_ppu_byte_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sync = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       ack_o = 1'b0;
  logic       full, empty, overflow, stb_o, line_done, timeout;
  logic [3:0] level;
  logic [7:0] data_o;
  logic [4:0] byte_idx;

  int n_chk = 0;
  int n_fail = 0;
  int ack_mode = 0;  // 0: hold low, 1: prompt responder, 2: random-delay responder
  bit mon_en = 1'b1;
  int ld_cnt = 0;

  // Reference model state
  logic [7:0] q[$];
  int         idx_m = 0;
  bit         ovf_m = 1'b0;
  logic [7:0] last_m = 8'h00;
  bit         prev_stb = 1'b0;
  bit         sync_e, wr_e;
  logic [7:0] wd_e;

  ppu_byte_tx dut (
    .clk       (clk),
    .rst       (rst),
    .sync      (sync),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .overflow  (overflow),
    .data_o    (data_o),
    .stb_o     (stb_o),
    .ack_o     (ack_o),
    .byte_idx  (byte_idx),
    .line_done (line_done),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Capture TB-driven inputs at the active edge (they are stable there)
  always @(posedge clk) begin
    sync_e = sync;
    wr_e   = wr_en;
    wd_e   = wr_data;
  end

  // PPU responder
  always @(negedge clk) begin
    if (rst || ack_mode == 0) begin
      ack_o = 1'b0;
    end else if (stb_o && !ack_o) begin
      if (ack_mode == 1 || $urandom_range(1, 0) == 1) ack_o = 1'b1;
    end else if (!stb_o && ack_o) begin
      if (ack_mode == 1 || $urandom_range(1, 0) == 1) ack_o = 1'b0;
    end
  end

  // Monitor: advance the model by one edge, then compare every observable output
  always @(negedge clk) begin
    int  pre;
    bit  ld_exp;
    if (rst) begin
      q.delete();
      idx_m = 0; ovf_m = 1'b0; last_m = 8'h00; prev_stb = 1'b0;
      chk("rst_stb", stb_o, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_level", level, 0);
      chk("rst_idx", byte_idx, 0);
      chk("rst_data", data_o, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_ld", line_done, 0);
      chk("rst_timeout", timeout, 0);
    end else if (mon_en) begin
      pre = q.size();
      ld_exp = 1'b0;
      if (stb_o && !prev_stb) begin
        if (pre == 0) begin
          chk("strobe_without_data", 1, 0);
        end else begin
          last_m = q.pop_front();
          chk("data_at_strobe", data_o, last_m);
        end
      end else begin
        chk("data_stable", data_o, last_m);
      end
      if (sync_e) begin
        idx_m = 0;
      end else if (prev_stb && !stb_o) begin
        ld_exp = (idx_m == 31);
        idx_m  = (idx_m + 1) % 32;
      end
      if (wr_e) begin
        if (pre < 8) q.push_back(wd_e);
        else ovf_m = 1'b1;
      end
      if (sync_e) ovf_m = 1'b0;
      chk("level", level, q.size());
      chk("full", full, q.size() == 8);
      chk("empty", empty, q.size() == 0);
      chk("overflow", overflow, ovf_m);
      chk("byte_idx", byte_idx, idx_m);
      chk("line_done", line_done, ld_exp);
`ifndef PPU_TX_TIMEOUT_EN
      chk("timeout_tied", timeout, 0);
`endif
      if (line_done) ld_cnt++;
      prev_stb = stb_o;
    end
  end

  task automatic wr(input logic [7:0] b, input bit guard);
    int g = 0;
    @(negedge clk);
    while (guard && full && g < 200) begin
      @(negedge clk);
      g++;
    end
    wr_en = 1'b1;
    wr_data = b;
  endtask

  task automatic wr_stop();
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic sync_pulse();
    @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int stable = 0;
    for (int c = 0; c < budget && stable < 3; c++) begin
      @(negedge clk);
      if (empty && !stb_o && !ack_o) stable++;
      else stable = 0;
    end
    if (stable < 3) chk("wait_idle_expired", 0, 1);
  endtask

  task automatic wait_stb(input int budget);
    int c = 0;
    while (!stb_o && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (!stb_o) chk("wait_stb_expired", 0, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset mid-handshake drops stb_o at once
    ack_mode = 0;
    wr(8'h5A, 1'b1);
    wr_stop();
    wait_stb(20);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t1_stb", stb_o, 0);
    chk("t1_empty", empty, 1);
    chk("t1_level", level, 0);
    chk("t1_idx", byte_idx, 0);
    chk("t1_data", data_o, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Three bytes, prompt responder
    ack_mode = 1;
    wr(8'hA1, 1'b1);
    wr(8'hA2, 1'b1);
    wr(8'hA3, 1'b1);
    wr_stop();
    wait_idle(100);
    chk("t2_idx", byte_idx, 3);
    chk("t2_empty", empty, 1);

    // One full line, then one more byte
    sync_pulse();
    ld_cnt = 0;
    for (int i = 0; i < 32; i++) wr(8'(i), 1'b1);
    wr_stop();
    wait_idle(400);
    chk("t3_ld_count", ld_cnt, 1);
    chk("t3_idx_wrap", byte_idx, 0);
    wr(8'h20, 1'b1);
    wr_stop();
    wait_idle(50);
    chk("t3_idx_33", byte_idx, 1);

    // No ack: one byte sits in STROBE, eight fill the FIFO, the tenth overflows
    ack_mode = 0;
    for (int i = 0; i < 10; i++) wr(8'($urandom), 1'b0);
    wr_stop();
    chk("t4_full", full, 1);
    chk("t4_level", level, 8);
    chk("t4_ovf", overflow, 1);
    sync_pulse();
    chk("t4_ovf_clr", overflow, 0);
    chk("t4_level_kept", level, 8);
    ack_mode = 1;
    wait_idle(200);

    // sync while a byte is in STROBE
    sync_pulse();
    for (int i = 0; i < 5; i++) wr(8'($urandom), 1'b1);
    wr_stop();
    wait_idle(100);
    chk("t5_idx5", byte_idx, 5);
    ack_mode = 0;
    wr(8'hC3, 1'b1);
    wr_stop();
    wait_stb(20);
    sync_pulse();
    chk("t5_idx_sync", byte_idx, 0);
    chk("t5_stb_held", stb_o, 1);
    ack_mode = 1;
    wait_idle(50);
    chk("t5_idx_after", byte_idx, 1);

    // Random traffic, random responder timing, occasional sync
    ack_mode = 2;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      wr_en   = ($urandom_range(2, 0) != 0);
      wr_data = 8'($urandom);
      sync    = ($urandom_range(39, 0) == 0);
    end
    @(negedge clk);
    wr_en = 1'b0;
    sync  = 1'b0;
    wait_idle(1000);
    chk("rand_drained_level", level, 0);

`ifdef PPU_TX_TIMEOUT_EN
    // Ack never arrives: strobe abandoned after 255 cycles
    begin
      int n = 0;
      logic [4:0] idx_before;
      mon_en = 1'b0;
      ack_mode = 0;
      sync_pulse();
      idx_before = byte_idx;
      wr(8'h77, 1'b1);
      wr_stop();
      wait_stb(20);
      while (stb_o && n < 400) begin
        @(negedge clk);
        n++;
      end
      chk("t6_stb_cycles", n, 255);
      chk("t6_timeout", timeout, 1);
      chk("t6_idx", byte_idx, idx_before);
      wr(8'h78, 1'b1);
      wr_stop();
      wait_stb(20);
      chk("t6_next_data", data_o, 8'h78);
      sync_pulse();
      chk("t6_timeout_clr", timeout, 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
